// File: rtl/axi4_lite_Defs.sv
// rtl/axi4_lite_Defs.sv - shared widths, response codes and read FSM states for the AXI4-Lite slave
package axi4_lite_Defs;

  localparam int Addr_Width       = 32;
  localparam int Data_Width       = 32;
  localparam int Byte_Offset_Bits = $clog2(Data_Width / 8);

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    RESP  = 2'b10
  } rd_state_t;

  // Byte address to word index; sub-word offset bits are dropped by truncation.
  function automatic logic [Addr_Width-1:0] word_index(input logic [Addr_Width-1:0] byte_addr);
    return byte_addr >> Byte_Offset_Bits;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_rd_engine.sv
// rtl/axi4_lite_slave_rd_engine.sv - AXI4-Lite slave read engine: AR capture, memory fetch, R response
module axi4_lite_slave_rd_engine
  import axi4_lite_Defs::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 1,
  localparam int MemAddrW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [Addr_Width-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [Data_Width-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  mem_rd_en,
  output logic [MemAddrW-1:0]   mem_rd_addr,
  input  logic [Data_Width-1:0] mem_rd_data
);

  // Final latency count value; the counter starts at 0 in the cycle mem_rd_en is high.
  localparam logic [2:0]            LatCount  = 3'(RD_LATENCY);
  localparam logic [Addr_Width-1:0] MemDepthW = Addr_Width'(MEM_DEPTH);

  rd_state_t             r_state;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [Data_Width-1:0] r_rdata;
  resp_t                 r_rresp;
  logic                  r_mem_rd_en;
  logic [MemAddrW-1:0]   r_mem_rd_addr;
  logic [2:0]            r_lat_cnt;

  logic [Addr_Width-1:0] w_word;
  logic                  w_in_range;
  logic                  w_ar_hs;
  logic                  w_r_hs;

  assign w_word     = word_index(ARADDR);
  assign w_in_range = (w_word < MemDepthW);
  assign w_ar_hs    = ARVALID && r_arready;
  assign w_r_hs     = r_rvalid && RREADY;

  // Read FSM: one transaction in flight, every output registered.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state       <= IDLE;
      r_arready     <= 1'b0;
      r_rvalid      <= 1'b0;
      r_rdata       <= '0;
      r_rresp       <= OKAY;
      r_mem_rd_en   <= 1'b0;
      r_mem_rd_addr <= '0;
      r_lat_cnt     <= '0;
    end else begin
      r_mem_rd_en <= 1'b0;
      case (r_state)
        IDLE: begin
          r_arready <= 1'b1;
          if (w_ar_hs) begin
            r_arready <= 1'b0;
            if (w_in_range) begin
              r_state       <= FETCH;
              r_mem_rd_en   <= 1'b1;
              r_mem_rd_addr <= w_word[MemAddrW-1:0];
              r_lat_cnt     <= '0;
            end else begin
              // Out-of-range word: answer at once without touching memory.
              r_state  <= RESP;
              r_rvalid <= 1'b1;
              r_rdata  <= '0;
              r_rresp  <= DECERR;
            end
          end
        end
        FETCH: begin
          if (r_lat_cnt == LatCount) begin
            r_state  <= RESP;
            r_rvalid <= 1'b1;
            r_rdata  <= mem_rd_data;
            r_rresp  <= OKAY;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        RESP: begin
          if (w_r_hs) begin
            r_state   <= IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_arready <= 1'b0;
          r_rvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign ARREADY     = r_arready;
  assign RVALID      = r_rvalid;
  assign RDATA       = r_rdata;
  assign RRESP       = r_rresp;
  assign mem_rd_en   = r_mem_rd_en;
  assign mem_rd_addr = r_mem_rd_addr;

endmodule
